// File: rtl/ram_sp_arb_pkg.sv
// ram_sp_arb_pkg: FSM encoding and sizing helpers shared by ram_sp_arbiter and rr_arbiter
package ram_sp_arb_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;
  function automatic int rd_cnt_w(input int rd_cycles);
    return $clog2(rd_cycles + 1);
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker from i_ptr, fixed lowest-index priority when RAM_SP_ARB_FIXED_PRIO_EN is defined
module rr_arbiter
  import ram_sp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx
);
  // scan from the highest offset down so the nearest requester at or after the start point wins
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef RAM_SP_ARB_FIXED_PRIO_EN
      if (i_req[k]) begin
        o_idx = IW'(k);
        o_gnt = NUM_REQ'(1) << k;
      end
`else
      if (i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_idx = IW'((int'(i_ptr) + k) % NUM_REQ);
        o_gnt = NUM_REQ'(1) << ((int'(i_ptr) + k) % NUM_REQ);
      end
`endif
    end
  end
endmodule

// File: rtl/ram_sp_arbiter.sv
// ram_sp_arbiter: shares one async single-port RAM between NUM_REQ requesters (RAM_SP_ARB_FIXED_PRIO_EN: fixed priority)
module ram_sp_arbiter
  import ram_sp_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int RD_CYCLES  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           busy,
  output logic                           ram_cs,
  output logic                           ram_oe,
  output logic                           ram_we,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  output logic [DATA_WIDTH-1:0]          ram_wdata,
  output logic                           ram_wdata_oe,
  input  logic [DATA_WIDTH-1:0]          ram_rdata
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = rd_cnt_w(RD_CYCLES);
  logic [1:0]            r_state;
  logic                  r_pend;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [IW-1:0]         r_owner;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            w_next;
  logic                  w_last;
  logic                  w_take;
  logic                  w_start;
  logic                  w_done;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [IW-1:0]         w_idx;
  logic [IW-1:0]         w_ptr;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .i_req (req),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );
`ifdef RAM_SP_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IW-1:0] r_ptr;
  assign w_ptr = r_ptr;
  // advance the round-robin start point past each winner
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (w_take) r_ptr <= w_idx == IW'(NUM_REQ - 1) ? '0 : w_idx + 1'b1;
  end
`endif
  // arbitration happens on every edge that lands in IDLE, so the grant cycle is itself an IDLE cycle
  always_comb begin
    w_last  = r_cnt == CW'(RD_CYCLES - 1);
    w_start = r_state == S_IDLE && r_pend;
    w_done  = r_state == S_READ && w_last;
    w_next  = r_state == S_IDLE  ? (r_pend ? (r_we ? S_WRITE : S_READ) : S_IDLE) :
              r_state == S_WRITE ? S_TURN :
              r_state == S_TURN  ? S_IDLE :
              w_last             ? S_IDLE : S_READ;
    w_take  = w_next == S_IDLE && |req;
  end
  // state, captured command and registered RAM/client outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pend       <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_owner      <= '0;
      r_cnt        <= '0;
      gnt          <= '0;
      rvalid       <= '0;
      rdata        <= '0;
      busy         <= 1'b0;
      ram_cs       <= 1'b0;
      ram_oe       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_wdata_oe <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_pend       <= w_take;
      gnt          <= w_take ? w_gnt : '0;
      if (w_take) begin
        r_we    <= req_we[w_idx];
        r_addr  <= req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
        r_wdata <= req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
        r_owner <= w_idx;
      end
      r_cnt        <= r_state == S_READ && !w_last ? r_cnt + 1'b1 : '0;
      busy         <= w_next != S_IDLE;
      ram_cs       <= w_next == S_WRITE || w_next == S_READ;
      ram_oe       <= w_next == S_READ;
      ram_we       <= w_next == S_WRITE;
      ram_wdata_oe <= w_next == S_WRITE;
      if (w_start) ram_addr <= r_addr;
      if (w_start && r_we) ram_wdata <= r_wdata;
      rvalid       <= w_done ? NUM_REQ'(1) << r_owner : '0;
      if (w_done) rdata <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_ram_sp_arbiter.sv
// tb_ram_sp_arbiter: directed and randomized checks of ram_sp_arbiter against a transaction-level model (honours RAM_SP_ARB_FIXED_PRIO_EN)
module tb_ram_sp_arbiter;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int N  = 4;
  localparam int RD = 3;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            ram_cs;
  logic            ram_oe;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic            ram_wdata_oe;
  logic [DW-1:0]   ram_rdata;
  logic [DW-1:0]   mem [256];
  logic [DW-1:0]   ref_mem [256];
  logic            mem_clr = 1'b1;
  bit              mon = 1'b0;
  int              n_chk = 0;
  int              n_err = 0;
  int              cyc = 0;
  int              rv_due = -1;
  int              rv_who = 0;
  logic [DW-1:0]   rv_data = '0;
  int              ptr = 0;

  always #5 clk = ~clk;

  ram_sp_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N), .RD_CYCLES(RD)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .busy         (busy),
    .ram_cs       (ram_cs),
    .ram_oe       (ram_oe),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_wdata_oe (ram_wdata_oe),
    .ram_rdata    (ram_rdata)
  );

  assign ram_rdata = (ram_cs && ram_oe) ? mem[ram_addr] : '0;

  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (ram_cs && ram_we && ram_wdata_oe) mem[ram_addr] <= ram_wdata;
  end

  always @(negedge clk) begin
    if (mon) begin
      n_chk++;
      assert ((ram_we & ram_oe) === 1'b0) else begin
        n_err++;
        $error("FAIL we_oe_excl observed we=%b oe=%b expected not both high", ram_we, ram_oe);
      end
      n_chk++;
      assert ((ram_wdata_oe & ~(ram_cs & ram_we)) === 1'b0) else begin
        n_err++;
        $error("FAIL wdata_oe_only_write observed wdata_oe=%b cs=%b we=%b expected wdata_oe only with cs&we", ram_wdata_oe, ram_cs, ram_we);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ctl_chk(input string tag, input bit cs, input bit oe, input bit we, input bit woe, input bit b);
    chk(tag, {ram_cs, ram_oe, ram_we, ram_wdata_oe, busy}, {cs, oe, we, woe, b});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (mon) begin
      if (cyc == rv_due) begin
        chk("rvalid", rvalid, 32'(1) << rv_who);
        chk("rdata", rdata, rv_data);
        rv_due = -1;
      end else chk("rvalid_quiet", rvalid, 0);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
`ifdef RAM_SP_ARB_FIXED_PRIO_EN
      if (m[k]) return k;
`else
      if (m[(ptr + k) % N]) return (ptr + k) % N;
`endif
    end
    return 0;
  endfunction

  task automatic put(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic grant(input int w);
    if (req_we[w]) ref_mem[req_addr[w*AW +: AW]] = req_wdata[w*DW +: DW];
    else begin
      rv_due  = cyc + RD + 1;
      rv_who  = w;
      rv_data = ref_mem[req_addr[w*AW +: AW]];
    end
    ptr = (w + 1) % N;
    req[w] = 1'b0;
  endtask

  task automatic expect_gnt(input logic [N-1:0] m, output int w, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (gnt == '0 && lat < 16);
    w = pick(m);
    chk("gnt", gnt, 32'(1) << w);
    grant(w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    rv_due = -1;
    ptr = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int w;
    int lat;
    int last;
    bit last_we;
    bit tight;
    logic [N-1:0] m;
    logic [N-1:0] pend;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    do_reset();
    mem_clr = 1'b0;
    mon = 1'b1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    ctl_chk("rst_ctl", 0, 0, 0, 0, 0);

    put(0, 1'b1, 8'h10, 8'hA5);
    expect_gnt(4'b0001, w, lat);
    chk("wr_gnt_lat", lat, 1);
    ctl_chk("wr_gnt_ctl", 0, 0, 0, 0, 0);
    step();
    ctl_chk("wr_ctl", 1, 0, 1, 1, 1);
    chk("wr_addr", ram_addr, 8'h10);
    chk("wr_data", ram_wdata, 8'hA5);
    step();
    ctl_chk("turn_ctl", 0, 0, 0, 0, 1);
    chk("turn_addr", ram_addr, 8'h10);
    step();
    ctl_chk("wr_idle_ctl", 0, 0, 0, 0, 0);

    put(2, 1'b0, 8'h10, 8'h00);
    expect_gnt(4'b0100, w, lat);
    chk("rd_gnt_lat", lat, 1);
    for (int k = 0; k < RD; k++) begin
      step();
      ctl_chk("rd_ctl", 1, 1, 0, 0, 1);
      chk("rd_addr", ram_addr, 8'h10);
    end
    step();
    ctl_chk("rd_idle_ctl", 0, 0, 0, 0, 0);

    do_reset();
    for (int i = 0; i < N; i++) put(i, 1'b0, 8'(i), 8'h00);
    for (int k = 0; k < 5; k++) begin
      expect_gnt(req, w, lat);
      chk(k == 0 ? "cont_first_lat" : "cont_spacing", lat, k == 0 ? 1 : RD + 1);
      req[w] = 1'b1;
    end
    req = '0;
    repeat (RD + 2) step();

    put(1, 1'b1, 8'h20, 8'h3C);
    put(3, 1'b0, 8'h20, 8'h00);
    expect_gnt(4'b1010, w, lat);
    step();
    ctl_chk("b2b_wr_ctl", 1, 0, 1, 1, 1);
    step();
    ctl_chk("b2b_turn_ctl", 0, 0, 0, 0, 1);
    expect_gnt(4'b1000, w, lat);
    chk("b2b_rd_lat", lat, 1);
    repeat (RD) step();
    step();

    put(0, 1'b0, 8'h10, 8'h00);
    expect_gnt(4'b0001, w, lat);
    step();
    step();
    ctl_chk("rst_mid_rd_ctl", 1, 1, 0, 0, 1);
    rst = 1'b1;
    rv_due = -1;
    ptr = 0;
    step();
    ctl_chk("rst_abort_ctl", 0, 0, 0, 0, 0);
    chk("rst_abort_gnt", gnt, 0);
    rst = 1'b0;
    step();
    step();
    put(2, 1'b1, 8'h30, 8'h77);
    expect_gnt(4'b0100, w, lat);
    chk("post_rst_lat", lat, 1);
    step();
    chk("post_rst_addr", ram_addr, 8'h30);
    chk("post_rst_data", ram_wdata, 8'h77);
    step();
    step();

    put(0, 1'b1, 8'h40, 8'h11);
    expect_gnt(4'b0001, w, lat);
    req_addr[0 +: AW] = 8'h41;
    req_wdata[0 +: DW] = 8'h22;
    step();
    chk("stable_addr", ram_addr, 8'h40);
    chk("stable_data", ram_wdata, 8'h11);
    step();
    step();

    last = 0;
    last_we = 1'b0;
    tight = 1'b0;
    for (int r = 0; r < 30; r++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if (m[i]) put(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
      pend = m;
      while (pend != '0) begin
        expect_gnt(pend, w, lat);
        if (tight) chk("rand_spacing", cyc - last, last_we ? 3 : RD + 1);
        last = cyc;
        last_we = req_we[w];
        pend[w] = 1'b0;
        tight = pend != '0;
      end
      repeat (RD + 2) step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
